// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [0:31] dmem_addr;
   logic [0:3]  dmem_be;
   logic [0:31] dmem_wdata;
   logic        dmem_ack;
   logic [0:31] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, aligns and extends loads,
// builds store lanes/byte enables, stalls the pipe during an access and
// raises mem_trap on misaligned/illegal sizes or a bus timeout.
module mem_stage #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        flush,
   input  logic [0:31] alu_result,
   input  logic [0:31] next_pc,
   input  logic [0:31] store_data,
   input  logic [0:4]  dest_reg,
   input  logic        pc_to_reg,
   input  logic        reg_write,
   input  logic        mem_to_reg,
   input  logic        mem_write,
   input  logic        load_sign,
   input  logic [0:1]  dsize,
   mem_stage_if.master dmem,
   output logic        stall,
   output logic        wb_valid,
   output logic [0:31] wb_data,
   output logic [0:4]  wb_dest,
   output logic        wb_reg_write,
   output logic        mem_trap
);

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

   stateT       state, stateNext;
   logic [7:0]  timer, timerNext;
   logic        errorFlag, errorNext;
   logic        flushedFlag, flushedNext;
   logic [0:31] captureReg, captureNext;

   logic        memOp;
   logic        misalign;
   logic [0:1]  offset;
   logic [0:7]  byteSel;
   logic [0:15] halfSel;
   logic [0:31] loadValue;
   logic [0:3]  storeBe;
   logic [0:31] storeWord;

   assign memOp  = in_valid & (mem_to_reg | mem_write);
   assign offset = alu_result[30:31];

   // Size legality and alignment of the current effective address
   always_comb begin
      misalign = 1'b0;
      case (dsize)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = offset[1];
         2'b10:   misalign = (offset != 2'b00);
         default: misalign = 1'b1;
      endcase
   end

   // Load lane selection (big-endian) with sign/zero extension into the low bits
   always_comb begin
      byteSel = '0;
      case (offset)
         2'b00:   byteSel = dmem.dmem_rdata[0:7];
         2'b01:   byteSel = dmem.dmem_rdata[8:15];
         2'b10:   byteSel = dmem.dmem_rdata[16:23];
         default: byteSel = dmem.dmem_rdata[24:31];
      endcase
      halfSel = offset[0] ? dmem.dmem_rdata[16:31] : dmem.dmem_rdata[0:15];
      case (dsize)
         2'b00:   loadValue = {{24{load_sign & byteSel[0]}}, byteSel};
         2'b01:   loadValue = {{16{load_sign & halfSel[0]}}, halfSel};
         default: loadValue = dmem.dmem_rdata;
      endcase
   end

   // Store byte enables and lane replication
   always_comb begin
      storeBe   = '0;
      storeWord = store_data;
      case (dsize)
         2'b00: begin
            storeBe   = 4'b1000 >> offset;
            storeWord = {4{store_data[24:31]}};
         end
         2'b01: begin
            storeBe   = offset[0] ? 4'b0011 : 4'b1100;
            storeWord = {2{store_data[16:31]}};
         end
         default: begin
            storeBe   = '1;
            storeWord = store_data;
         end
      endcase
   end

   // State, access timer, error/flush flags and load capture register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         errorFlag   <= 1'b0;
         flushedFlag <= 1'b0;
         captureReg  <= '0;
      end else begin
         state       <= stateNext;
         timer       <= timerNext;
         errorFlag   <= errorNext;
         flushedFlag <= flushedNext;
         captureReg  <= captureNext;
      end
   end

   // Next-state logic, bus drive and writeback outputs
   always_comb begin
      stateNext        = state;
      timerNext        = timer;
      errorNext        = errorFlag;
      flushedNext      = flushedFlag;
      captureNext      = captureReg;
      dmem.dmem_req    = 1'b0;
      dmem.dmem_we     = 1'b0;
      dmem.dmem_addr   = '0;
      dmem.dmem_be     = '0;
      dmem.dmem_wdata  = '0;
      stall            = 1'b0;
      wb_valid         = 1'b0;
      wb_data          = '0;
      wb_dest          = dest_reg;
      mem_trap         = 1'b0;

      case (state)
         IDLE: begin
            wb_valid = in_valid & ~flush;
            wb_data  = pc_to_reg ? next_pc : alu_result;
            mem_trap = memOp & misalign & ~flush;
            if (memOp & ~misalign & ~flush) begin
               stall       = 1'b1;
               wb_valid    = 1'b0;
               stateNext   = ACCESS;
               timerNext   = '0;
               errorNext   = 1'b0;
               flushedNext = 1'b0;
            end
         end
         ACCESS: begin
            // Inputs are frozen by stall, so the bus fields stay stable
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = mem_write;
            dmem.dmem_addr  = {alu_result[0:29], 2'b00};
            dmem.dmem_be    = storeBe;
            dmem.dmem_wdata = storeWord;
            stall           = 1'b1;
            if (flush) flushedNext = 1'b1;
            if (dmem.dmem_ack) begin
               captureNext = loadValue;
               stateNext   = DONE;
            end else if (timer == TIMER_LAST) begin
               errorNext = 1'b1;
               stateNext = DONE;
            end else begin
               timerNext = timer + 8'd1;
            end
         end
         DONE: begin
            wb_valid  = ~flushedFlag & ~flush;
            wb_data   = captureReg;
            mem_trap  = errorFlag;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase

      // Outputs read as zero while reset is held
      if (reset) begin
         dmem.dmem_req   = 1'b0;
         dmem.dmem_we    = 1'b0;
         dmem.dmem_addr  = '0;
         dmem.dmem_be    = '0;
         dmem.dmem_wdata = '0;
         stall           = 1'b0;
         wb_valid        = 1'b0;
         wb_data         = '0;
         wb_dest         = '0;
         mem_trap        = 1'b0;
      end
   end

   assign wb_reg_write = reg_write & wb_valid & ~mem_trap;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized operations
// checked against an arithmetic reference model of load/store behaviour.
module tb_mem_stage;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, flush;
   logic [31:0] alu_result, next_pc, store_data;
   logic [4:0]  dest_reg;
   logic        pc_to_reg, reg_write, mem_to_reg, mem_write, load_sign;
   logic [1:0]  dsize;
   logic        stall, wb_valid, wb_reg_write, mem_trap;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;

   int nAsserts = 0;
   int nFail    = 0;

   mem_stage_if bus();

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
      .alu_result(alu_result), .next_pc(next_pc), .store_data(store_data),
      .dest_reg(dest_reg), .pc_to_reg(pc_to_reg), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .mem_write(mem_write), .load_sign(load_sign),
      .dsize(dsize), .dmem(bus), .stall(stall), .wb_valid(wb_valid),
      .wb_data(wb_data), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
      .mem_trap(mem_trap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit modelMisalign(input logic [1:0] sz, input logic [31:0] a);
      int off = int'(a[1:0]);
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd1) return (off % 2) != 0;
      if (sz == 2'd2) return off != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] modelBe(input logic [1:0] sz, input logic [31:0] a);
      int off = int'(a[1:0]);
      if (sz == 2'd0) return 4'(1 << (3 - off));
      if (sz == 2'd1) return (off >= 2) ? 4'b0011 : 4'b1100;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] sd);
      if (sz == 2'd0) return (sd & 32'hFF) * 32'h01010101;
      if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h00010001;
      return sd;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] rd, input bit sgn);
      int off = int'(a[1:0]);
      int w;
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (rd >> ((3 - off) * 8)) & 32'hFF;
         w = 8;
      end else if (sz == 2'd1) begin
         v = (rd >> ((1 - off / 2) * 16)) & 32'hFFFF;
         w = 16;
      end else begin
         return rd;
      end
      if (sgn && v[w-1]) v = v | (32'hFFFF_FFFF << w);
      return v;
   endfunction

   // One instruction through MEM; inputs are applied just after a rising edge
   // and the task returns just after the edge where the instruction leaves.
   task automatic doOp(input string nm, input bit isLoad, input bit isStore,
                       input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rd, input bit sgn,
                       input int ackAt, input bit flushInAcc, input bit ptr,
                       input logic [31:0] npc, input logic [4:0] dst, input bit rw);
      bit expMem, expMis, expTrap, expValid;
      int reqCycles, stallCnt, expReq;
      in_valid   = 1'b1;
      flush      = 1'b0;
      mem_to_reg = isLoad;
      mem_write  = isStore;
      dsize      = sz;
      alu_result = addr;
      store_data = sd;
      load_sign  = sgn;
      pc_to_reg  = ptr;
      next_pc    = npc;
      dest_reg   = dst;
      reg_write  = rw;
      expMem = isLoad | isStore;
      expMis = modelMisalign(sz, addr);
      @(negedge clk);
      if (!expMem || expMis) begin
         expTrap = expMem & expMis;
         check({nm, ".stall"}, 32'(stall), 32'd0);
         check({nm, ".req"}, 32'(bus.dmem_req), 32'd0);
         check({nm, ".wbValid"}, 32'(wb_valid), 32'd1);
         check({nm, ".wbData"}, wb_data, ptr ? npc : addr);
         check({nm, ".trap"}, 32'(mem_trap), 32'(expTrap));
         check({nm, ".wbRegWrite"}, 32'(wb_reg_write), 32'(rw & ~expTrap));
         check({nm, ".wbDest"}, 32'(wb_dest), 32'(dst));
         @(posedge clk); #1;
         return;
      end
      check({nm, ".idleStall"}, 32'(stall), 32'd1);
      check({nm, ".idleReq"}, 32'(bus.dmem_req), 32'd0);
      check({nm, ".idleValid"}, 32'(wb_valid), 32'd0);
      stallCnt  = (stall === 1'b1) ? 1 : 0;
      reqCycles = 0;
      @(posedge clk); #1;
      @(negedge clk);
      while (bus.dmem_req === 1'b1 && reqCycles < 20) begin
         reqCycles++;
         if (stall === 1'b1) stallCnt++;
         check({nm, ".addr"}, bus.dmem_addr, addr & 32'hFFFF_FFFC);
         check({nm, ".we"}, 32'(bus.dmem_we), 32'(isStore));
         check({nm, ".be"}, 32'(bus.dmem_be), 32'(modelBe(sz, addr)));
         if (isStore) check({nm, ".wdata"}, bus.dmem_wdata, modelWdata(sz, sd));
         if (flushInAcc && reqCycles == 1) flush = 1'b1;
         if (reqCycles == ackAt) begin
            bus.dmem_ack   = 1'b1;
            bus.dmem_rdata = rd;
         end
         @(posedge clk); #1;
         bus.dmem_ack   = 1'b0;
         bus.dmem_rdata = $urandom;
         flush          = 1'b0;
         @(negedge clk);
      end
      expReq   = (ackAt == 0) ? int'(TO) : ackAt;
      expTrap  = (ackAt == 0);
      expValid = !flushInAcc;
      check({nm, ".reqCycles"}, 32'(reqCycles), 32'(expReq));
      check({nm, ".stallCycles"}, 32'(stallCnt), 32'(expReq + 1));
      check({nm, ".doneStall"}, 32'(stall), 32'd0);
      check({nm, ".doneValid"}, 32'(wb_valid), 32'(expValid));
      check({nm, ".doneTrap"}, 32'(mem_trap), 32'(expTrap));
      check({nm, ".doneRegWrite"}, 32'(wb_reg_write), 32'(rw & expValid & ~expTrap));
      if (isLoad && expValid && !expTrap)
         check({nm, ".loadData"}, wb_data, modelLoad(sz, addr, rd, sgn));
      @(posedge clk); #1;
   endtask

   initial begin
      bit ld, st;
      int kind, ack;
      reset = 1'b1;
      in_valid = 1'b1; flush = 1'b0; alu_result = 32'h1234; next_pc = 32'h40;
      store_data = '0; dest_reg = 5'd3; pc_to_reg = 1'b0; reg_write = 1'b1;
      mem_to_reg = 1'b1; mem_write = 1'b0; load_sign = 1'b0; dsize = 2'd2;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
      #2;
      check("rst.req", 32'(bus.dmem_req), 32'd0);
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.wbValid", 32'(wb_valid), 32'd0);
      check("rst.wbData", wb_data, 32'd0);
      check("rst.trap", 32'(mem_trap), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      doOp("lb", 1, 0, 2'd0, 32'h103, 32'h0, 32'h1122_3380, 1, 2, 0, 0, 32'h0, 5'd5, 1);
      doOp("sh", 0, 1, 2'd1, 32'h102, 32'h0000_BEEF, 32'h0, 0, 1, 0, 0, 32'h0, 5'd0, 0);
      doOp("lwMis", 1, 0, 2'd2, 32'h101, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 5'd7, 1);
      doOp("lwTimeout", 1, 0, 2'd2, 32'h200, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 5'd8, 1);
      doOp("addLink", 0, 0, 2'd2, 32'h999, 32'h0, 32'h0, 0, 1, 0, 1, 32'h40, 5'd31, 1);
      doOp("lwFlush", 1, 0, 2'd2, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 3, 1, 0, 32'h0, 5'd9, 1);
      doOp("lhu", 1, 0, 2'd1, 32'h402, 32'h0, 32'h1234_8765, 0, 1, 0, 0, 32'h0, 5'd4, 1);
      doOp("illegal", 0, 1, 2'd3, 32'h500, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0, 5'd2, 0);

      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 2);
         ld   = (kind == 0);
         st   = (kind == 1);
         ack  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
         doOp("rand", ld, st, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), ack, ($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset while an access is outstanding
      in_valid = 1'b1; flush = 1'b0; mem_to_reg = 1'b1; mem_write = 1'b0;
      dsize = 2'd2; alu_result = 32'h600;
      @(posedge clk); #1;
      check("midRst.reqBefore", 32'(bus.dmem_req), 32'd1);
      reset = 1'b1;
      #1;
      check("midRst.req", 32'(bus.dmem_req), 32'd0);
      check("midRst.stall", 32'(stall), 32'd0);
      check("midRst.wbValid", 32'(wb_valid), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("postRst.req", 32'(bus.dmem_req), 32'd0);
      check("postRst.wbValid", 32'(wb_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
